controle_multiciclo: RTL and testbench

//  Multicycle control FSM for the RISC-V datapath. Drives estado, which the instruction reader

---
 rtl/riscv_ctrl_pkg.sv | 38 +++
 rtl/controle_multiciclo.sv | 184 ++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// state encodings, opcode constants and datapath control codes.
package riscv_ctrl_pkg;

    // The reader and datapath see these codes directly on estado.
    typedef enum logic [3:0] {
        BUSCA    = 4'b0000,
        DECOD    = 4'b0001,
        EXEC_R   = 4'b0010,
        EXEC_I   = 4'b0011,
        CALC_END = 4'b0100,
        MEM_LE   = 4'b0101,
        MEM_ESC  = 4'b0110,
        ESCREVE  = 4'b0111,
        DESVIO   = 4'b1000,
        INICIO   = 4'b1110,
        PARADO   = 4'b1111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_MAIS1  = 2'b00;
    localparam logic [1:0] PC_DESVIO = 2'b01;

    // Only beq (000) and bne (001) are implemented branches.
    function automatic logic desvio_valido(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001);
    endfunction

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RISC-V datapath: decodes opcode/funct3,
// sequences per-state strobes, waits on the data-memory handshake with a
// timeout, counts retired instructions and halts on illegal instruction
// or memory timeout.
module controle_multiciclo
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CONT_W      = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              zero,
    input  logic              mem_pronto,
    output logic [3:0]        estado,
    output logic              pc_escreve,
    output logic [1:0]        pc_src,
    output logic              reg_escreve,
    output logic              mem_le,
    output logic              mem_escreve,
    output logic              alu_src,
    output logic              mem_para_reg,
    output logic [1:0]        alu_op,
    output logic [CONT_W-1:0] instr_contador,
    output logic              parado,
    output logic              erro
);

    estado_t    st, st_prox;
    logic       bne_q;       // funct3[0] of the branch being executed
    logic       load_q;      // current memory instruction is a load
    logic [7:0] tmo_cnt;
    logic       tmo_fim;
    logic       aposenta;
    logic       seta_erro;
    logic       em_mem;

    assign estado  = st;
    assign em_mem  = (st == MEM_LE) || (st == MEM_ESC);
    // Counter would reach MEM_TIMEOUT on this cycle if pronto stays low.
    assign tmo_fim = (tmo_cnt == 8'(MEM_TIMEOUT - 1)) && !mem_pronto;

    // State register plus per-instruction decode latches and halt cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= INICIO;
            bne_q  <= 1'b0;
            load_q <= 1'b0;
            erro   <= 1'b0;
        end else begin
            st <= st_prox;
            if (st == DECOD) begin
                bne_q  <= funct3[0];
                load_q <= (opcode == OP_LOAD);
            end
            if (seta_erro) begin
                erro <= 1'b1;
            end
        end
    end

    // Next-state logic, retire and timeout-halt qualifiers.
    always_comb begin
        st_prox   = st;
        aposenta  = 1'b0;
        seta_erro = 1'b0;
        case (st)
            INICIO:   st_prox = BUSCA;
            BUSCA:    st_prox = DECOD;
            DECOD: begin
                if (opcode == OP_R) begin
                    st_prox = EXEC_R;
                end else if (opcode == OP_I) begin
                    st_prox = EXEC_I;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    st_prox = CALC_END;
                end else if (opcode == OP_BRANCH && desvio_valido(funct3)) begin
                    st_prox = DESVIO;
                end else begin
                    st_prox = PARADO;
                end
            end
            EXEC_R:   st_prox = ESCREVE;
            EXEC_I:   st_prox = ESCREVE;
            CALC_END: st_prox = load_q ? MEM_LE : MEM_ESC;
            // pronto is tested before the timeout so a late ready still completes
            MEM_LE: begin
                if (mem_pronto) begin
                    st_prox = ESCREVE;
                end else if (tmo_fim) begin
                    st_prox   = PARADO;
                    seta_erro = 1'b1;
                end
            end
            MEM_ESC: begin
                if (mem_pronto) begin
                    st_prox  = BUSCA;
                    aposenta = 1'b1;
                end else if (tmo_fim) begin
                    st_prox   = PARADO;
                    seta_erro = 1'b1;
                end
            end
            ESCREVE: begin
                st_prox  = BUSCA;
                aposenta = 1'b1;
            end
            DESVIO: begin
                st_prox  = BUSCA;
                aposenta = 1'b1;
            end
            PARADO:   st_prox = PARADO;
            default:  st_prox = INICIO;
        endcase
    end

    // Moore output decoder; pc_escreve in DESVIO also depends on zero.
    always_comb begin
        pc_escreve   = 1'b0;
        pc_src       = PC_MAIS1;
        reg_escreve  = 1'b0;
        mem_le       = 1'b0;
        mem_escreve  = 1'b0;
        alu_src      = 1'b0;
        mem_para_reg = 1'b0;
        alu_op       = ALU_ADD;
        parado       = 1'b0;
        case (st)
            BUSCA: begin
                pc_escreve = 1'b1;
                pc_src     = PC_MAIS1;
            end
            EXEC_R: begin
                alu_src = 1'b0;
                alu_op  = ALU_FUNCT;
            end
            EXEC_I: begin
                alu_src = 1'b1;
                alu_op  = ALU_FUNCT;
            end
            CALC_END: begin
                alu_src = 1'b1;
                alu_op  = ALU_ADD;
            end
            MEM_LE:  mem_le      = 1'b1;
            MEM_ESC: mem_escreve = 1'b1;
            ESCREVE: begin
                reg_escreve  = 1'b1;
                mem_para_reg = load_q;
            end
            DESVIO: begin
                alu_op     = ALU_SUB;
                pc_src     = PC_DESVIO;
                pc_escreve = zero ^ bne_q;
            end
            PARADO:  parado = 1'b1;
            default: ;
        endcase
    end

    // Memory wait counter: held at zero outside the memory states, so it
    // starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (em_mem && !mem_pronto) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_contador <= '0;
        end else if (aposenta) begin
            instr_contador <= instr_contador + CONT_W'(1);
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: per-instruction expected
// state/strobe sequences built from the instruction class, memory latency
// and zero flag, with randomized instruction streams.
module tb_controle_multiciclo;

    localparam int MEM_TO = 15;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          zero = 1'b0;
    logic          mem_pronto = 1'b0;
    logic [3:0]    estado;
    logic          pc_escreve;
    logic [1:0]    pc_src;
    logic          reg_escreve;
    logic          mem_le;
    logic          mem_escreve;
    logic          alu_src;
    logic          mem_para_reg;
    logic [1:0]    alu_op;
    logic [CW-1:0] instr_contador;
    logic          parado;
    logic          erro;
    logic [15:0]   obs;

    int n_chk = 0;
    int n_err = 0;
    int exp_count = 0;

    controle_multiciclo #(.CONT_W(CW), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_pronto(mem_pronto), .estado(estado),
        .pc_escreve(pc_escreve), .pc_src(pc_src), .reg_escreve(reg_escreve),
        .mem_le(mem_le), .mem_escreve(mem_escreve), .alu_src(alu_src),
        .mem_para_reg(mem_para_reg), .alu_op(alu_op),
        .instr_contador(instr_contador), .parado(parado), .erro(erro)
    );

    always #5 clk = ~clk;

    assign obs = {estado, pc_escreve, pc_src, reg_escreve, mem_le, mem_escreve,
                  alu_src, mem_para_reg, alu_op, parado, erro};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output vector in the same packing as obs.
    function automatic logic [15:0] E(input logic [3:0] st, input logic pcw,
                                      input logic [1:0] pcs, input logic rw,
                                      input logic ml, input logic me, input logic as_,
                                      input logic m2r, input logic [1:0] aop,
                                      input logic par, input logic err);
        return {st, pcw, pcs, rw, ml, me, as_, m2r, aop, par, err};
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // One clock: check outputs at the falling edge, then randomize
    // mem_pronto (callers override it where it matters).
    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(exp));
        mem_pronto = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs), 32'(E(4'b1110, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0)));
        chk("rst_cont", 32'(instr_contador), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'(obs), 32'(E(4'b1110, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0)));
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic halt_checks(input logic err);
        repeat (3) cyc("parado", E(4'b1111, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, err));
        do_reset();
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 illegal (uses bad_op)
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic z,
                             input int lat, input logic [6:0] bad_op);
        logic [6:0] op;
        case (kind)
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            default: op = bad_op;
        endcase
        cyc("busca", E(4'b0000, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        chk("contador", 32'(instr_contador), 32'(exp_count % (1 << CW)));
        opcode = op;
        funct3 = f3;
        zero   = z;
        cyc("decod", E(4'b0001, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        case (kind)
            0, 1: begin
                cyc(kind == 0 ? "exec_r" : "exec_i",
                    E(kind == 0 ? 4'b0010 : 4'b0011, 0, 2'b00, 0, 0, 0,
                      kind == 1, 0, 2'b10, 0, 0));
                cyc("escreve", E(4'b0111, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 0));
                exp_count++;
            end
            2, 3: begin
                cyc("calc_end", E(4'b0100, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 0));
                for (int k = 0; k < MEM_TO; k++) begin
                    if (kind == 2)
                        cyc("mem_le", E(4'b0101, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0));
                    else
                        cyc("mem_esc", E(4'b0110, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0));
                    mem_pronto = (k == lat);
                    if (k == lat) break;
                end
                if (lat >= MEM_TO) begin
                    halt_checks(1'b1);
                end else begin
                    if (kind == 2)
                        cyc("escreve_ld", E(4'b0111, 0, 2'b00, 1, 0, 0, 0, 1, 2'b00, 0, 0));
                    exp_count++;
                end
            end
            4: begin
                cyc("desvio", E(4'b1000, z ^ f3[0], 2'b01, 0, 0, 0, 0, 0, 2'b01, 0, 0));
                exp_count++;
            end
            default: halt_checks(1'b0);
        endcase
    endtask

    initial begin
        int r;
        int kind;
        int lat;
        logic [2:0] f3;
        logic [6:0] bop;

        #3;
        do_reset();

        run_instr(0, 3'b000, 1'b0, 0, '0);      // add
        run_instr(2, 3'b010, 1'b0, 3, '0);      // lw, pronto after 3 cycles
        run_instr(3, 3'b010, 1'b0, 0, '0);      // sw, immediate pronto
        run_instr(4, 3'b000, 1'b1, 0, '0);      // beq taken
        run_instr(4, 3'b000, 1'b0, 0, '0);      // beq not taken
        run_instr(4, 3'b001, 1'b1, 0, '0);      // bne not taken
        run_instr(4, 3'b001, 1'b0, 0, '0);      // bne taken
        run_instr(2, 3'b010, 1'b0, 14, '0);     // pronto on the 15th cycle
        run_instr(1, 3'b000, 1'b0, 0, '0);
        run_instr(3, 3'b010, 1'b0, 14, '0);
        run_instr(2, 3'b010, 1'b0, 15, '0);     // timeout
        run_instr(5, 3'b000, 1'b0, 0, 7'b1111111);
        run_instr(5, 3'b010, 1'b0, 0, 7'b1100011);  // branch with bad funct3
        repeat (17) run_instr(0, 3'b000, 1'b0, 0, '0);  // counter wraps
        run_instr(0, 3'b000, 1'b0, 0, '0);

        // reset in the middle of a load
        cyc("busca_mid", E(4'b0000, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        opcode = 7'b0000011;
        cyc("decod_mid", E(4'b0001, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        cyc("calc_mid", E(4'b0100, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        mem_pronto = 1'b0;
        cyc("mem_mid", E(4'b0101, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0));
        mem_pronto = 1'b0;
        #2;
        do_reset();

        run_instr(3, 3'b010, 1'b0, 20, '0);     // store timeout

        for (int i = 0; i < 200; i++) begin
            r   = $urandom_range(0, 99);
            f3  = 3'($urandom);
            lat = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 5);
            bop = 7'($urandom);
            if (r < 20)      kind = 0;
            else if (r < 40) kind = 1;
            else if (r < 60) kind = 2;
            else if (r < 75) kind = 3;
            else if (r < 96) kind = 4;
            else             kind = 5;
            if (kind == 4) f3 = {2'b00, f3[0]};
            if (kind == 5) begin
                if (f3[2]) begin
                    bop = 7'b1100011;
                    f3  = 3'($urandom_range(2, 7));
                end else if (legal_op(bop)) begin
                    bop = 7'b1111111;
                end
            end
            run_instr(kind, f3, 1'($urandom), lat, bop);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
